ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- EX-stage multiply/divide unit of the MIPS32 5-stage pipeline; owns the HI/LO registers.
- Consumes the 2-bit forwarding selects produced by the forwarding unit and picks rs/rt operands from the register file, EX/MEM or MEM/WB.
- Runs MULT/MULTU/DIV/DIVU iteratively and handles MTHI/MTLO.
- Raises a stall request to the hazard logic while busy, and supplies HI/LO to MFHI/MFLO.

Parameters:
- XLEN, 32, operand/HI/LO width.
- CNT_W, 5, iteration counter width (must satisfy 2^CNT_W = XLEN).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ForwardA  input  2  rs select: 00 = id_ex_rs_data, 10 = ex_mem_result, 01 = mem_wb_result, 11 = treated as 00
- ForwardB  input  2  rt select, same encoding as ForwardA
- id_ex_rs_data  input  XLEN  rs from register file
- id_ex_rt_data  input  XLEN  rt from register file
- ex_mem_result  input  XLEN  EX/MEM forwarded value
- mem_wb_result  input  XLEN  MEM/WB forwarded value
- md_valid  input  1  mul/div-class instruction present in EX
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others no-op
- ex_flush  input  1  kill the instruction currently in EX
- hilo_read  input  1  MFHI/MFLO in EX this cycle
- hi  output  XLEN  HI register
- lo  output  XLEN  LO register
- busy  output  1  iterative operation in flight
- stall_req  output  1  freeze IF/ID/EX
- div_zero  output  1  one-cycle pulse: divide by zero completed

Behaviour:
- Reset: state IDLE; hi, lo = 0; counter = 0; busy, stall_req, div_zero = 0. rst mid-operation aborts immediately.
- Operand mux is combinational and uses the encodings in Ports.
- Accept: at edge when state == IDLE, md_valid, !ex_flush and md_op ∈ {0..3}. Forwarded operands are captured at that edge.
- ex_flush blocks acceptance only; an in-flight operation belongs to an older instruction and is never killed by flush.
- MTHI/MTLO: when IDLE, write the forwarded rs value to hi/lo at the edge; no busy. If not IDLE, stall and retry.
- States: IDLE -> MUL or DIV on accept. MUL/DIV -> IDLE after exactly 32 iterations (counter 0..31). DIV with divisor 0 -> DZ -> IDLE.
- MUL: radix-2 shift-add on magnitudes. Signed ops take abs() and negate the 64-bit product at completion if the operand signs differ. Result {hi,lo} = product.
- DIV: restoring division on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - lo = quotient, hi = remainder.
  - -2^31 / -1 gives lo = 0x80000000, hi = 0.
- Latency: accept at edge T. busy is high for cycles T+1..T+32. hi/lo are updated at the edge ending T+32 and are visible in T+33, when busy = 0.
- Divide by zero: hi/lo unchanged; DZ lasts 1 cycle (busy high) and div_zero pulses in that cycle.
- busy = (state != IDLE).
- stall_req = busy && md_valid && (md_op ≠ no-op) OR busy && hilo_read. This is combinational.
- hilo_read with busy = 0 never stalls. hi/lo outputs always hold architectural values and never partial results.
- A new md_valid in the completion cycle T+33 is accepted (IDLE); back-to-back issue is legal.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single combinational XLEN×XLEN signed/unsigned multiply registered into hi/lo. busy is high for 1 cycle (T+1) and the result is visible in T+2. DIV is unchanged.
- Undefined: 32-cycle iterative multiply as above.

Decomposition:
- Shared package mips32_pkg: md_op encodings (MD_MULT..MD_MTLO), forward-select constants (FWD_REG 00, FWD_MEM 01, FWD_EX 10), XLEN.
- One natural sub-module: muldiv_core (iterative shift-add/restoring datapath plus counter).
- ex_muldiv_unit keeps the operand mux, FSM control, HI/LO registers and the stall logic.

Test Plan:
- Forwarding: ForwardA=10, ex_mem_result=7, ForwardB=01, mem_wb_result=6, MULTU -> hi=0, lo=42 at T+33; busy high exactly 32 cycles.
- Signed: MULT 0xFFFFFFFD × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU 9/0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> div_zero pulses 1 cycle, hi/lo unchanged, IDLE after 1 cycle.
- Hazards: hilo_read during busy -> stall_req=1 every busy cycle and 0 at T+33. ex_flush with md_valid -> no accept, hi/lo unchanged. Flush mid-operation -> operation completes normally.
- Reset: rst asserted at iteration 10 of DIVU -> next cycle busy=0, hi=lo=0. A following DIVU 100/7 gives lo=14, hi=2.
- MULDIV_FAST_MUL_EN: MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1 visible at T+2; busy high 1 cycle.

Source files
------------

// File: rtl/mips32_pkg.sv
// mips32_pkg: shared constants for the MIPS32 EX-stage mul/div slice.
//   - md_op encodings (MD_MULT..MD_MTLO); 6/7 are no-ops
//   - forwarding select constants (FWD_REG/FWD_MEM/FWD_EX; 11 aliases FWD_REG)
//   - mul/div FSM state encoding
//   - fwd_mux helper shared by the rs/rt operand selects
package mips32_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DZ   = 2'd3
  } md_state_e;

  // 11 is not produced by the forwarding unit; it falls back to the regfile.
  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                              input logic [XLEN-1:0] reg_v,
                                              input logic [XLEN-1:0] ex_v,
                                              input logic [XLEN-1:0] mem_v);
    case (sel)
      FWD_EX:  fwd_mux = ex_v;
      FWD_MEM: fwd_mux = mem_v;
      default: fwd_mux = reg_v;
    endcase
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_core.sv
// muldiv_core: iterative datapath for the EX-stage mul/div unit.
//   clk, rst          clock, synchronous active-high reset
//   start             load operands (magnitudes + result sign flags), clear counter
//   step              perform one iteration
//   is_div, is_signed operation class captured at start
//   a, b              raw operands (multiplicand/multiplier or dividend/divisor)
//   last              counter is at its final iteration (2^CNT_W - 1)
//   res_hi, res_lo    sign-corrected result of the *current* step, valid when
//                     last && step, so the owner can latch it on that edge
// One 2*XLEN work register is shared:
//   MUL: {partial product, remaining multiplier bits} (shift-add, LSB first)
//   DIV: {partial remainder, dividend/quotient bits}  (restoring, MSB first)
module muldiv_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            is_div,
  input  logic            is_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  logic [2*XLEN-1:0] work, work_nxt, prod_fix;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [CNT_W-1:0]  cnt;
  logic              div_q, neg_q, neg_r;
  logic [XLEN:0]     mul_sum, div_trial;

  assign a_mag = (is_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
  assign b_mag = (is_signed && b[XLEN-1]) ? (~b + 1'b1) : b;

  always_ff @(posedge clk) begin
    if (rst) begin
      work  <= '0;
      opnd  <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      work  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      opnd  <= is_div ? b_mag : a_mag;
      cnt   <= '0;
      div_q <= is_div;
      neg_q <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
      neg_r <= is_signed & a[XLEN-1];
    end else if (step) begin
      work <= work_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

  always_comb begin
    mul_sum   = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : '0);
    // Remainder is always < divisor, so the MSB of the XLEN+1 bit difference
    // is a clean borrow flag.
    div_trial = {work[2*XLEN-1:XLEN], work[XLEN-1]} - {1'b0, opnd};
    work_nxt  = '0;
    if (!div_q)
      work_nxt = {mul_sum, work[XLEN-1:1]};
    else if (!div_trial[XLEN])
      work_nxt = {div_trial[XLEN-1:0], work[XLEN-2:0], 1'b1};
    else
      work_nxt = {work[2*XLEN-2:0], 1'b0};
  end

  assign last     = (cnt == {CNT_W{1'b1}});
  assign prod_fix = neg_q ? -work_nxt : work_nxt;

  always_comb begin
    if (div_q) begin
      res_lo = neg_q ? -work_nxt[XLEN-1:0]      : work_nxt[XLEN-1:0];
      res_hi = neg_r ? -work_nxt[2*XLEN-1:XLEN] : work_nxt[2*XLEN-1:XLEN];
    end else begin
      res_lo = prod_fix[XLEN-1:0];
      res_hi = prod_fix[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: MIPS32 EX-stage multiply/divide unit, owner of HI/LO.
//   clk, rst                  clock, synchronous active-high reset
//   ForwardA/ForwardB         rs/rt forwarding selects (00 reg, 10 EX/MEM, 01 MEM/WB)
//   id_ex_rs/rt_data          register file operands
//   ex_mem_result             EX/MEM forwarded value
//   mem_wb_result             MEM/WB forwarded value
//   md_valid, md_op           mul/div-class instruction in EX and its opcode
//   ex_flush                  EX instruction is killed (blocks acceptance only)
//   hilo_read                 MFHI/MFLO in EX
//   hi, lo                    architectural HI/LO
//   busy, stall_req           operation in flight / freeze IF-ID-EX
//   div_zero                  one-cycle pulse when a divide by zero retires
// Build option: define MULDIV_FAST_MUL_EN to replace the 32-cycle multiply
// with a single-cycle array multiply (DIV stays iterative).
module ex_muldiv_unit
  import mips32_pkg::*;
#(
  parameter int XLEN  = mips32_pkg::XLEN,
  parameter int CNT_W = mips32_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ForwardA,
  input  logic [1:0]      ForwardB,
  input  logic [XLEN-1:0] id_ex_rs_data,
  input  logic [XLEN-1:0] id_ex_rt_data,
  input  logic [XLEN-1:0] ex_mem_result,
  input  logic [XLEN-1:0] mem_wb_result,
  input  logic            md_valid,
  input  logic [2:0]      md_op,
  input  logic            ex_flush,
  input  logic            hilo_read,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall_req,
  output logic            div_zero
);

  md_state_e       state, state_nxt;
  logic [XLEN-1:0] op_a, op_b;
  logic            idle, issue, accept_md, accept_mt;
  logic            is_div_op, is_signed_op, md_nop;
  logic            core_last, mul_done, wr_res;
  logic [XLEN-1:0] core_hi, core_lo, res_hi, res_lo;

  assign op_a = fwd_mux(ForwardA, id_ex_rs_data, ex_mem_result, mem_wb_result);
  assign op_b = fwd_mux(ForwardB, id_ex_rt_data, ex_mem_result, mem_wb_result);

  assign idle         = (state == ST_IDLE);
  assign issue        = idle && md_valid && !ex_flush;
  assign accept_md    = issue && !md_op[2];                  // ops 0..3
  assign accept_mt    = issue && (md_op == MD_MTHI || md_op == MD_MTLO);
  assign is_div_op    = md_op[1];
  assign is_signed_op = !md_op[0];
  assign md_nop       = md_op[2] & md_op[1];                 // ops 6,7

  muldiv_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_md),
    .step      (state == ST_MUL || state == ST_DIV),
    .is_div    (is_div_op),
    .is_signed (is_signed_op),
    .a         (op_a),
    .b         (op_b),
    .last      (core_last),
    .res_hi    (core_hi),
    .res_lo    (core_lo)
  );

`ifdef MULDIV_FAST_MUL_EN
  // Operands are captured at accept; the product is formed during the single
  // busy cycle. Low 2*XLEN bits of the sign-extended product are exact for
  // both signed and unsigned operands.
  logic [XLEN-1:0]   fa_q, fb_q;
  logic              fs_q;
  logic [2*XLEN-1:0] fa_ext, fb_ext, fast_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      fa_q <= '0;
      fb_q <= '0;
      fs_q <= 1'b0;
    end else if (accept_md) begin
      fa_q <= op_a;
      fb_q <= op_b;
      fs_q <= is_signed_op;
    end
  end

  assign fa_ext    = {{XLEN{fs_q & fa_q[XLEN-1]}}, fa_q};
  assign fb_ext    = {{XLEN{fs_q & fb_q[XLEN-1]}}, fb_q};
  assign fast_prod = fa_ext * fb_ext;
  assign mul_done  = 1'b1;
  assign res_hi    = (state == ST_MUL) ? fast_prod[2*XLEN-1:XLEN] : core_hi;
  assign res_lo    = (state == ST_MUL) ? fast_prod[XLEN-1:0]      : core_lo;
`else
  assign mul_done  = core_last;
  assign res_hi    = core_hi;
  assign res_lo    = core_lo;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_res    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept_md) begin
          if (is_div_op && op_b == '0) state_nxt = ST_DZ;
          else if (is_div_op)          state_nxt = ST_DIV;
          else                         state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_nxt = ST_IDLE;
          wr_res    = 1'b1;
        end
      end
      ST_DIV: begin
        if (core_last) begin
          state_nxt = ST_IDLE;
          wr_res    = 1'b1;
        end
      end
      ST_DZ:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // HI/LO only ever take complete results, so MFHI/MFLO outside busy is safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (accept_mt) begin
      if (md_op == MD_MTHI) hi <= op_a;
      else                  lo <= op_a;
    end else if (wr_res) begin
      hi <= res_hi;
      lo <= res_lo;
    end
  end

  assign busy      = !idle;
  assign div_zero  = (state == ST_DZ);
  assign stall_req = busy && ((md_valid && !md_nop) || hilo_read);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed + randomized bench for ex_muldiv_unit with an
// arithmetic reference model of HI/LO.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ForwardA, ForwardB;
  logic [31:0] id_ex_rs_data, id_ex_rt_data, ex_mem_result, mem_wb_result;
  logic        md_valid, ex_flush, hilo_read;
  logic [2:0]  md_op;
  logic [31:0] hi, lo;
  logic        busy, stall_req, div_zero;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk(clk), .rst(rst), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result),
    .md_valid(md_valid), .md_op(md_op), .ex_flush(ex_flush),
    .hilo_read(hilo_read), .hi(hi), .lo(lo), .busy(busy),
    .stall_req(stall_req), .div_zero(div_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sel_src(input logic [1:0] s, input logic [31:0] r,
                                          input logic [31:0] e, input logic [31:0] m);
    if (s == 2'b10) return e;
    if (s == 2'b01) return m;
    return r;
  endfunction

  // Architectural result of one mul/div/mt op on the HI/LO model.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: if (b != 0) begin
              q = sa / sb; r = sa % sb;
              m_lo = q[31:0]; m_hi = r[31:0];
            end
      3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // Entered just after a negedge; returns at the negedge of the first idle cycle.
  task automatic issue(input logic [2:0] op, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] exv, input logic [31:0] mwv,
                       input bit hr, input bit flush_mid);
    logic [31:0] a, b;
    int n, sbad, dz, lat;
    a = sel_src(fa, rs, exv, mwv);
    b = sel_src(fb, rt, exv, mwv);
    ForwardA = fa; ForwardB = fb;
    id_ex_rs_data = rs; id_ex_rt_data = rt;
    ex_mem_result = exv; mem_wb_result = mwv;
    md_op = op; md_valid = 1'b1; ex_flush = 1'b0; hilo_read = hr;
    @(negedge clk);
    md_valid = 1'b0;
    ex_flush = flush_mid;
    // operands must have been captured at accept
    id_ex_rs_data = $urandom; id_ex_rt_data = $urandom;
    ex_mem_result = $urandom; mem_wb_result = $urandom;
    #1;
    model(op, a, b);
    if (op >= 3'd4) begin
      chk("mt_busy", {63'd0, busy}, 64'd0);
      chk("mt_hi", {32'd0, hi}, {32'd0, m_hi});
      chk("mt_lo", {32'd0, lo}, {32'd0, m_lo});
      hilo_read = 1'b0;
      return;
    end
    if (op[1] && b == 0) lat = 1;
`ifdef MULDIV_FAST_MUL_EN
    else if (!op[1]) lat = 1;
`endif
    else lat = 32;
    n = 0; sbad = 0; dz = 0;
    while (busy && n < 100) begin
      n++;
      if (stall_req !== hr) sbad++;
      if (div_zero) dz++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(n), 64'(lat));
    chk("stall_busy", 64'(sbad), 64'd0);
    chk("div_zero_pulses", 64'(dz), (op[1] && b == 0) ? 64'd1 : 64'd0);
    chk("stall_done", {63'd0, stall_req}, 64'd0);
    chk("hi", {32'd0, hi}, {32'd0, m_hi});
    chk("lo", {32'd0, lo}, {32'd0, m_lo});
    hilo_read = 1'b0;
    ex_flush  = 1'b0;
  endtask

  initial begin
    logic [1:0]  fa, fb;
    logic [31:0] v0, v1, v2, v3;
    logic [2:0]  op;
    rst = 1'b1; md_valid = 1'b0; md_op = 3'd0; ex_flush = 1'b0; hilo_read = 1'b0;
    ForwardA = 2'b00; ForwardB = 2'b00;
    id_ex_rs_data = 0; id_ex_rt_data = 0; ex_mem_result = 0; mem_wb_result = 0;
    repeat (2) @(negedge clk);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_stall", {63'd0, stall_req}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    rst = 1'b0;

    // forwarding: rs from EX/MEM (7), rt from MEM/WB (6)
    issue(3'd1, 2'b10, 2'b01, 32'hDEAD_0001, 32'hDEAD_0002, 32'd7, 32'd6, 1'b0, 1'b0);
    // signed multiply with MFHI/MFLO waiting the whole time
    issue(3'd0, 2'b00, 2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b1, 1'b0);
    // signed divide, flush raised mid-operation must not kill it
    issue(3'd2, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, 1'b1);
    issue(3'd2, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    // divide by zero leaves preloaded HI/LO intact
    issue(3'd4, 2'b00, 2'b00, 32'h11, 0, 0, 0, 1'b0, 1'b0);
    issue(3'd5, 2'b00, 2'b00, 32'h22, 0, 0, 0, 1'b0, 1'b0);
    issue(3'd3, 2'b00, 2'b00, 32'd9, 32'd0, 0, 0, 1'b1, 1'b0);
    issue(3'd1, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);

    // flushed instruction is never accepted
    md_op = 3'd0; md_valid = 1'b1; ex_flush = 1'b1;
    id_ex_rs_data = 32'd3; id_ex_rt_data = 32'd4;
    @(negedge clk);
    md_valid = 1'b0; ex_flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("flush_lo", {32'd0, lo}, {32'd0, m_lo});

    // reset at iteration 10 of a DIVU; MTLO during busy must stall
    md_op = 3'd3; md_valid = 1'b1; ForwardA = 2'b00; ForwardB = 2'b00;
    id_ex_rs_data = 32'd1000; id_ex_rt_data = 32'd3;
    @(negedge clk);
    md_valid = 1'b0;
    repeat (3) @(negedge clk);
    md_op = 3'd5; md_valid = 1'b1; #1;
    chk("stall_md", {63'd0, stall_req}, 64'd1);
    @(negedge clk);
    md_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = 0; m_lo = 0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    issue(3'd3, 2'b00, 2'b00, 32'd100, 32'd7, 0, 0, 1'b0, 1'b0);

    // randomized ops with random forwarding
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 5));
      fa = 2'($urandom_range(0, 3));
      fb = 2'($urandom_range(0, 3));
      v0 = $urandom; v1 = $urandom; v2 = $urandom; v3 = $urandom;
      case ($urandom_range(0, 5))
        0: begin v1 = 0; v2 = 0; v3 = 0; end
        1: begin v1 = v1 & 32'hF; v2 = v2 & 32'hFF; end
        default: ;
      endcase
      issue(op, fa, fb, v0, v1, v2, v3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
